// File: rtl/imp_rd_addr_gen_pkg.sv
// imp_pkg: shared types and constants for the image read address generator.
//   imp_addr_state_e : FSM state encoding (IDLE, CALC, ISSUE, FIN)
//   imp_rd_cfg_t     : image window configuration captured at job start
//   IMP_4K_BYTES     : AXI 4 KB address boundary size
package imp_pkg;

    localparam int IMP_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        IMP_IDLE  = 2'd0,
        IMP_CALC  = 2'd1,
        IMP_ISSUE = 2'd2,
        IMP_FIN   = 2'd3
    } imp_addr_state_e;

    typedef struct packed {
        logic [31:0] baddr;
        logic [31:0] pitch;
        logic [15:0] hsize;
        logic [15:0] vsize;
        logic [7:0]  minx;
        logic [7:0]  miny;
    } imp_rd_cfg_t;

endpackage

// File: rtl/imp_rd_addr_gen_if.sv
// imp_rd_addr_gen_if: byte-granular read request channel.
//   req_valid  : request valid (master -> slave)
//   req_ready  : consumer accepts (slave -> master)
//   req_addr   : request byte address
//   req_nbytes : request byte count, 1..MAX_BURST_BYTES
interface imp_rd_addr_gen_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [12:0]           req_nbytes;

    modport master (
        output req_valid,
        output req_addr,
        output req_nbytes,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_nbytes,
        output req_ready
    );
endinterface

// File: rtl/imp_rd_addr_gen_chunk.sv
// imp_chunk_size: byte count of the next request.
//   addr_i  : address of the next request
//   rem_i   : bytes left in the current row
//   chunk_o : min(rem_i, MAX_BURST_BYTES), further limited to the distance to
//             the next 4 KB boundary when IMP_RD_ADDR_GEN_4K_SPLIT_EN is defined.
module imp_chunk_size
    import imp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_BURST_BYTES = 64,
    parameter int REM_W           = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [REM_W-1:0]      rem_i,
    output logic [12:0]           chunk_o
);

    logic [31:0] lim_s;
    logic [31:0] to4k_s;
    logic        unused_addr_s;

    // Upper address bits never influence the chunk size.
    assign unused_addr_s = ^addr_i;

    // Bytes still ahead of the next 4 KB boundary (1..4096).
    assign to4k_s = 32'(IMP_4K_BYTES) - {20'd0, addr_i[11:0]};

    // Minimum of remaining row bytes, burst limit and optional 4 KB limit.
    always_comb begin
        lim_s = 32'(MAX_BURST_BYTES);
        if (32'(rem_i) < lim_s) begin
            lim_s = 32'(rem_i);
        end else begin
            lim_s = lim_s;
        end
`ifdef IMP_RD_ADDR_GEN_4K_SPLIT_EN
        if (to4k_s < lim_s) begin
            lim_s = to4k_s;
        end else begin
            lim_s = lim_s;
        end
`endif
        chunk_o = lim_s[12:0];
    end

endmodule

// File: rtl/imp_rd_addr_gen.sv
// imp_rd_addr_gen: walks a 2-D image window row by row and emits byte-granular
// read requests over a valid/ready channel.
//   clk, rst_n               : clock, asynchronous active-low reset
//   MST_U0_RD_IMP_*          : window configuration, captured on a rising ST edge
//   req_if (master)          : request channel (valid, ready, addr, nbytes)
//   busy                     : job in progress
//   done                     : one-cycle pulse at job end
// Optional build macro IMP_RD_ADDR_GEN_4K_SPLIT_EN keeps every request inside
// a single 4 KB page.
module imp_rd_addr_gen
    import imp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BPP_BYTES       = 1,
    parameter int MAX_BURST_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MST_U0_RD_IMP_SRC_BADDR,
    input  logic [31:0] MST_U0_RD_IMP_ADR_PITCH,
    input  logic [15:0] MST_U0_RD_IMP_HSIZE,
    input  logic [15:0] MST_U0_RD_IMP_VSIZE,
    input  logic [7:0]  MST_U0_RD_IMP_COOR_MINX,
    input  logic [7:0]  MST_U0_RD_IMP_COOR_MINY,
    input  logic        MST_U0_RD_IMP_ST,
    imp_rd_addr_gen_if.master req_if,
    output logic        busy,
    output logic        done
);

    localparam int REM_W = 16 + $clog2(BPP_BYTES);

    imp_addr_state_e       state_q, state_d;
    imp_rd_cfg_t           cfg_q, cfg_d;
    logic                  st_dly_q;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [15:0]           row_q, row_d;
    logic                  req_valid_q, req_valid_d;
    logic [12:0]           req_nbytes_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start_s;
    logic [ADDR_WIDTH-1:0] row_base_calc_s;
    logic [REM_W-1:0]      row_bytes_s;
    logic [ADDR_WIDTH-1:0] addr_step_s;
    logic [REM_W-1:0]      rem_step_s;
    logic [15:0]           row_step_s;
    logic [12:0]           chunk_s;

    assign start_s = MST_U0_RD_IMP_ST & ~st_dly_q;

    // First row start; address arithmetic wraps modulo 2^ADDR_WIDTH.
    assign row_base_calc_s = ADDR_WIDTH'(cfg_q.baddr)
                           + ADDR_WIDTH'(cfg_q.pitch) * ADDR_WIDTH'(cfg_q.miny)
                           + ADDR_WIDTH'(cfg_q.minx) * ADDR_WIDTH'(BPP_BYTES);
    assign row_bytes_s     = REM_W'(cfg_q.hsize) * REM_W'(BPP_BYTES);

    // Position after the currently presented request is accepted.
    assign addr_step_s = req_addr_q + ADDR_WIDTH'(req_nbytes_q);
    assign rem_step_s  = rem_q - REM_W'(req_nbytes_q);
    assign row_step_s  = row_q + 16'd1;

    // Chunk size is computed for the next-cycle request so req_nbytes is registered.
    imp_chunk_size #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .MAX_BURST_BYTES (MAX_BURST_BYTES),
        .REM_W           (REM_W)
    ) u_chunk (
        .addr_i  (req_addr_d),
        .rem_i   (rem_d),
        .chunk_o (chunk_s)
    );

    // Next-state and next-output logic of the address walker.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        row_base_d  = row_base_q;
        req_addr_d  = req_addr_q;
        rem_d       = rem_q;
        row_d       = row_q;
        req_valid_d = req_valid_q;
        done_d      = 1'b0;

        case (state_q)
            IMP_IDLE: begin
                if (start_s) begin
                    cfg_d.baddr = MST_U0_RD_IMP_SRC_BADDR;
                    cfg_d.pitch = MST_U0_RD_IMP_ADR_PITCH;
                    cfg_d.hsize = MST_U0_RD_IMP_HSIZE;
                    cfg_d.vsize = MST_U0_RD_IMP_VSIZE;
                    cfg_d.minx  = MST_U0_RD_IMP_COOR_MINX;
                    cfg_d.miny  = MST_U0_RD_IMP_COOR_MINY;
                    state_d     = IMP_CALC;
                end else begin
                    state_d = IMP_IDLE;
                end
            end
            IMP_CALC: begin
                if ((cfg_q.hsize == 16'd0) || (cfg_q.vsize == 16'd0)) begin
                    state_d = IMP_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d     = IMP_ISSUE;
                    row_base_d  = row_base_calc_s;
                    req_addr_d  = row_base_calc_s;
                    rem_d       = row_bytes_s;
                    row_d       = 16'd0;
                    req_valid_d = 1'b1;
                end
            end
            IMP_ISSUE: begin
                if (req_valid_q && req_if.req_ready) begin
                    if (rem_step_s == '0) begin
                        row_d = row_step_s;
                        if (row_step_s == cfg_q.vsize) begin
                            state_d     = IMP_FIN;
                            req_valid_d = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            // Next row follows back-to-back with no idle cycle.
                            row_base_d = row_base_q + ADDR_WIDTH'(cfg_q.pitch);
                            req_addr_d = row_base_q + ADDR_WIDTH'(cfg_q.pitch);
                            rem_d      = row_bytes_s;
                        end
                    end else begin
                        req_addr_d = addr_step_s;
                        rem_d      = rem_step_s;
                    end
                end else begin
                    state_d = IMP_ISSUE;
                end
            end
            IMP_FIN: begin
                state_d = IMP_IDLE;
            end
            default: begin
                state_d     = IMP_IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IMP_IDLE);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IMP_IDLE;
            cfg_q        <= '0;
            st_dly_q     <= 1'b0;
            row_base_q   <= '0;
            req_addr_q   <= '0;
            rem_q        <= '0;
            row_q        <= 16'd0;
            req_valid_q  <= 1'b0;
            req_nbytes_q <= 13'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            st_dly_q    <= MST_U0_RD_IMP_ST;
            row_base_q  <= row_base_d;
            req_addr_q  <= req_addr_d;
            rem_q       <= rem_d;
            row_q       <= row_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            if (req_valid_d) begin
                req_nbytes_q <= chunk_s;
            end else begin
                req_nbytes_q <= req_nbytes_q;
            end
        end
    end

    assign req_if.req_valid  = req_valid_q;
    assign req_if.req_addr   = req_addr_q;
    assign req_if.req_nbytes = req_nbytes_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_imp_rd_addr_gen.sv
// Self-checking bench for imp_rd_addr_gen: directed jobs from the test plan
// plus randomized windows and ready patterns, compared against a per-row
// request list computed directly from the window geometry.
module tb_imp_rd_addr_gen;

    localparam int AW   = 32;
    localparam int BPP  = 1;
    localparam int MAXB = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] baddr, pitch;
    logic [15:0] hsize, vsize;
    logic [7:0]  minx, miny;
    logic        st;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_a[$];
    int          exp_n[$];
    logic [31:0] obs_a[$];
    int          obs_n[$];

    always #5 clk = ~clk;

    imp_rd_addr_gen_if #(.ADDR_WIDTH(AW)) rif ();

    imp_rd_addr_gen #(
        .ADDR_WIDTH      (AW),
        .BPP_BYTES       (BPP),
        .MAX_BURST_BYTES (MAXB)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .MST_U0_RD_IMP_SRC_BADDR (baddr),
        .MST_U0_RD_IMP_ADR_PITCH (pitch),
        .MST_U0_RD_IMP_HSIZE     (hsize),
        .MST_U0_RD_IMP_VSIZE     (vsize),
        .MST_U0_RD_IMP_COOR_MINX (minx),
        .MST_U0_RD_IMP_COOR_MINY (miny),
        .MST_U0_RD_IMP_ST        (st),
        .req_if                  (rif.master),
        .busy                    (busy),
        .done                    (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected request list: each row start from the absolute row index.
    function automatic void model(input logic [31:0] b, input logic [31:0] p,
                                  input int hs, input int vs, input int mx, input int my);
        longint rb;
        longint full;
        logic [31:0] base;
        logic [31:0] a;
        longint off;
        longint n;
        exp_a.delete();
        exp_n.delete();
        rb = longint'(hs) * BPP;
        for (int r = 0; r < vs; r++) begin
            full = longint'(b) + longint'(my + r) * longint'(p) + longint'(mx) * BPP;
            base = full[31:0];
            off  = 0;
            while (off < rb) begin
                a = base + off[31:0];
                n = rb - off;
                if (n > MAXB) n = MAXB;
`ifdef IMP_RD_ADDR_GEN_4K_SPLIT_EN
                if (n > 4096 - longint'(a[11:0])) n = 4096 - longint'(a[11:0]);
`endif
                exp_a.push_back(a);
                exp_n.push_back(int'(n));
                off += n;
            end
        end
    endfunction

    // rmode: 0 ready always high, 1 random ready, 2 five-cycle stall on 2nd request.
    // retrig_at >= 0 toggles ST mid-job; rst_after > 0 resets once that many
    // requests were accepted.
    task automatic run_job(input string name, input logic [31:0] b, input logic [31:0] p,
                           input int hs, input int vs, input int mx, input int my,
                           input int rmode, input int retrig_at, input int rst_after);
        int first_valid = -1;
        int done_cyc = -1;
        int done_cnt = 0;
        int hcnt = 0;
        int stall_left = 5;
        bit stalled = 1'b0;
        logic [31:0] paddr = 32'd0;
        logic [12:0] pnb = 13'd0;
        bit finished = 1'b0;

        model(b, p, hs, vs, mx, my);
        obs_a.delete();
        obs_n.delete();
        baddr = b; pitch = p; hsize = 16'(hs); vsize = 16'(vs);
        minx = 8'(mx); miny = 8'(my);
        st = 1'b0;
        rif.req_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        st = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst_after > 0 && hcnt >= rst_after) begin
                chk({name, "_valid_before_rst"}, rif.req_valid, 1);
                rst_n = 1'b0;
                #1;
                chk({name, "_rst_valid"}, rif.req_valid, 0);
                chk({name, "_rst_busy"}, busy, 0);
                chk({name, "_rst_done"}, done, 0);
                st = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (i == 0) chk({name, "_busy_before"}, busy, 0);
            if (i == 1) begin
                chk({name, "_busy_rise"}, busy, 1);
                baddr = $urandom; pitch = $urandom; hsize = 16'($urandom);
                vsize = 16'($urandom); minx = 8'($urandom); miny = 8'($urandom);
            end
            if (stalled) begin
                chk({name, "_hold_valid"}, rif.req_valid, 1);
                chk({name, "_hold_addr"}, rif.req_addr, paddr);
                chk({name, "_hold_nbytes"}, rif.req_nbytes, pnb);
            end
            if (done_cyc >= 0) begin
                chk({name, "_done_single"}, done, 0);
                chk({name, "_busy_after"}, busy, 0);
                finished = 1'b1;
                break;
            end
            if (rif.req_valid && first_valid < 0) first_valid = i;
            if (done) begin
                done_cnt++;
                done_cyc = i;
            end
            if (rif.req_valid && rif.req_ready) begin
                obs_a.push_back(rif.req_addr);
                obs_n.push_back(int'(rif.req_nbytes));
                hcnt++;
            end
            stalled = rif.req_valid && !rif.req_ready;
            paddr   = rif.req_addr;
            pnb     = rif.req_nbytes;
            @(posedge clk); #1;
            case (rmode)
                1: rif.req_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (hcnt == 1 && stall_left > 0) begin
                        rif.req_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rif.req_ready = 1'b1;
                    end
                end
                default: rif.req_ready = 1'b1;
            endcase
            if (retrig_at >= 0 && i == retrig_at) st = 1'b0;
            if (retrig_at >= 0 && i == retrig_at + 2) st = 1'b1;
        end
        chk({name, "_finished"}, finished, 1);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_req_count"}, obs_a.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
            chk($sformatf("%s_addr[%0d]", name, k), obs_a[k], exp_a[k]);
            chk($sformatf("%s_nbytes[%0d]", name, k), obs_n[k], exp_n[k]);
        end
        if (exp_a.size() > 0) begin
            chk({name, "_first_valid_lat"}, first_valid, 2);
        end else begin
            chk({name, "_no_valid"}, first_valid, -1);
            chk({name, "_done_lat"}, done_cyc, 2);
        end
        st = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        st = 1'b0;
        rif.req_ready = 1'b0;
        baddr = 32'd0; pitch = 32'd0; hsize = 16'd0; vsize = 16'd0;
        minx = 8'd0; miny = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", rif.req_valid, 0);
        chk("reset_addr", rif.req_addr, 0);
        chk("reset_nbytes", rif.req_nbytes, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job("basic", 32'h0000_1000, 32'd16, 4, 6, 0, 0, 0, -1, 0);
        chk("basic_last_addr", obs_a.size() == 6 ? obs_a[5] : 32'hdead_beef, 32'h0000_1050);

        run_job("split", 32'h0000_2000, 32'd256, 100, 2, 2, 1, 0, -1, 0);
        chk("split_addr1", obs_a.size() == 4 ? obs_a[1] : 32'hdead_beef, 32'h0000_2142);
        chk("split_nb1", obs_n.size() == 4 ? obs_n[1] : -1, 36);

        run_job("b4k", 32'h0000_0FF0, 32'd64, 32, 1, 0, 0, 0, -1, 0);
`ifdef IMP_RD_ADDR_GEN_4K_SPLIT_EN
        chk("b4k_nb0", obs_n.size() > 0 ? obs_n[0] : -1, 16);
`else
        chk("b4k_nb0", obs_n.size() > 0 ? obs_n[0] : -1, 32);
`endif

        run_job("zero", 32'h0000_3000, 32'd16, 0, 5, 0, 0, 0, -1, 0);
        run_job("bp_retrig", 32'h0000_1000, 32'd16, 4, 6, 0, 0, 2, 3, 0);
        run_job("rst_mid", 32'h0000_1000, 32'd16, 4, 6, 0, 0, 0, -1, 2);
        run_job("after_rst", 32'h0000_1000, 32'd16, 4, 6, 0, 0, 0, -1, 0);

        for (int j = 0; j < 12; j++) begin
            run_job($sformatf("rand%0d", j), $urandom, 32'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 150)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1, (j % 3 == 0) ? 4 : -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
